interval_timer: RTL and testbench
=================================

# interval_timer

Programmable interval timer answering the traffic-light FSM's timer interface. The FSM requests an interval with `start_t`/`interval`; this block counts that many seconds and returns a one-cycle `expired`. It also holds the three programmable time parameters, written via `prog_sync`, and generates the 1 Hz tick from the system clock.

## Interface
- `TICK_DIV`, 100_000_000: clock cycles per second tick. Benches use 4.
- `DEF_BASE`, 6: reset value of the base interval, in seconds.
- `DEF_EXT`, 3: reset value of the extended interval, in seconds.
- `DEF_YEL`, 2: reset value of the yellow interval, in seconds.
- `clk` in 1: system clock. One clock only; all logic is on the rising edge.
- `reset_sync` in 1: synchronous, active-high reset.
- `start_t` in 1: one-cycle request to load and start the interval selected by `interval`.
- `interval` in 2: `00` base, `01` extended, `10` yellow, `11` treated as base.
- `prog_sync` in 1: parameter write strobe. A write occurs on every cycle it is high.
- `time_sel` in 2: parameter being written. Same coding as `interval`; `11` writes are ignored.
- `time_value` in 4: new parameter value, 0–15 seconds.
- `expired` out 1: one-cycle pulse when the interval completes.
- `tick_1hz` out 1: one-cycle pulse on each prescaler wrap.
- `remaining` out 4: seconds left in the current interval; 0 when idle.

## Operation
- Registers:
  - 27-bit prescaler `pre`.
  - 4-bit counter `cnt`.
  - Parameters `p_base`, `p_ext`, `p_yel`, 4 bits each.
  - State `st` ∈ {IDLE, RUN, DONE}.
- Reset values: `st`=IDLE, `pre`=0, `cnt`=0, `expired`=0, `tick_1hz`=0, parameters=DEF_*.
- `tick_1hz` = (`pre` == TICK_DIV−1). `pre` wraps to 0 on tick; otherwise it increments. It runs in every state.
- Load value L = param[`interval`]. A stored 0 loads as 1; no interval is shorter than 1 s.
- `start_t` is accepted in any state:
  - `cnt` ← L, `pre` ← 0, `st` ← RUN.
  - The first second is therefore always a full TICK_DIV cycles.
- RUN, on tick:
  - If `cnt`==1: `cnt` ← 0, `st` ← DONE.
  - Otherwise: `cnt` ← `cnt`−1.
- DONE: `expired`=1 for exactly this cycle, then `st` ← IDLE unless `start_t` is high.
- IDLE: holds `cnt`=0. Ticks are ignored.
- `expired` is a Moore output: `expired` = (`st`==DONE).
- `remaining` = `cnt`.
- Parameter writes:
  - On `prog_sync`, param[`time_sel`] ← `time_value`.
  - A write never affects a running count.
  - If a write and `start_t` occur in the same cycle, the load uses the pre-write value.
- Simultaneous events:
  - `start_t` in DONE: `expired` still pulses that cycle, and RUN begins next.
  - `start_t` in RUN: restarts silently; no `expired` for the abandoned interval.
  - `reset_sync` has priority over all inputs in its cycle.
- Reset mid-operation: returns to the reset values above on the next edge. Parameters revert to DEF_*, and no `expired` is emitted.

## Timing
- `start_t` sampled at edge k with load value L: `expired` is high between edges k+L·TICK_DIV and k+L·TICK_DIV+1, and low otherwise.
- `remaining` is L after edge k, and decrements at edges k+j·TICK_DIV.
- `tick_1hz` is high in the cycle before each of those edges.
- Write latency: a parameter written at edge k is used by a `start_t` sampled at edge k+1 or later.
- All outputs are registered or decoded from registers only. There is no combinational path from any input to any output.

## Test plan
All scenarios use TICK_DIV=4.
- **Reset defaults:** reset, then `start_t`=1, `interval`=00 at edge k → `expired` high only at edge k+24, one cycle wide. `remaining` steps 6,5,4,3,2,1,0.
- **Programming:** `prog_sync`, `time_sel`=01, `time_value`=9, then `start_t` with `interval`=01 one cycle later at edge k → `expired` at k+36.
- **Zero and reserved:** program yellow=0; start `interval`=10 → `expired` at k+4. Start `interval`=11 → `expired` at k+24.
- **Restart:** start base at k, then `start_t` again at k+10 → single `expired` at k+34, and none at k+24.
- **Collisions:** `start_t` coincident with DONE → `expired` still one cycle, reload proceeds. `prog_sync`+`start_t` same cycle (base←2) → load is 6, and the next start loads 2.
- **Reset mid-operation:** `reset_sync` at k+10 of a base run → `expired` never asserts, `remaining`=0, parameters back to 6/3/2.

Source files
------------

// File: rtl/interval_timer.sv
// Programmable interval timer: counts a selected number of 1 s ticks and pulses expired.
// Holds the base/extended/yellow interval parameters and divides the clock down to 1 Hz.
module interval_timer #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned DEF_BASE = 6,
  parameter int unsigned DEF_EXT  = 3,
  parameter int unsigned DEF_YEL  = 2
) (
  input  logic       clk,
  input  logic       reset_sync,
  input  logic       start_t,
  input  logic [1:0] interval,
  input  logic       prog_sync,
  input  logic [1:0] time_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       tick_1hz,
  output logic [3:0] remaining
);

  localparam logic [26:0] PreMax = 27'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      st_q, st_d;
  logic [26:0] pre_q, pre_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  p_base_q, p_base_d;
  logic [3:0]  p_ext_q, p_ext_d;
  logic [3:0]  p_yel_q, p_yel_d;
  logic [3:0]  sel_val;
  logic [3:0]  load_val;
  logic        tick;

  assign tick      = (pre_q == PreMax);
  assign tick_1hz  = tick;
  assign expired   = (st_q == StDone);
  assign remaining = cnt_q;

  // Load uses the registered parameters, so a same-cycle write is not seen.
  always_comb begin
    unique case (interval)
      2'b01:   sel_val = p_ext_q;
      2'b10:   sel_val = p_yel_q;
      default: sel_val = p_base_q;
    endcase
    load_val = (sel_val == 4'd0) ? 4'd1 : sel_val;
  end

  always_comb begin
    pre_d = tick ? 27'd0 : pre_q + 27'd1;
    st_d  = st_q;
    cnt_d = cnt_q;

    if (start_t) begin
      // Restarting aligns the prescaler so the first second is a full one.
      pre_d = 27'd0;
      cnt_d = load_val;
      st_d  = StRun;
    end else begin
      unique case (st_q)
        StRun: begin
          if (tick) begin
            if (cnt_q == 4'd1) begin
              cnt_d = 4'd0;
              st_d  = StDone;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
        StDone: begin
          st_d = StIdle;
        end
        default: begin
          cnt_d = 4'd0;
          st_d  = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    p_base_d = p_base_q;
    p_ext_d  = p_ext_q;
    p_yel_d  = p_yel_q;
    if (prog_sync) begin
      unique case (time_sel)
        2'b00:   p_base_d = time_value;
        2'b01:   p_ext_d  = time_value;
        2'b10:   p_yel_d  = time_value;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      st_q     <= StIdle;
      pre_q    <= 27'd0;
      cnt_q    <= 4'd0;
      p_base_q <= 4'(DEF_BASE);
      p_ext_q  <= 4'(DEF_EXT);
      p_yel_q  <= 4'(DEF_YEL);
    end else begin
      st_q     <= st_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      p_base_q <= p_base_d;
      p_ext_q  <= p_ext_d;
      p_yel_q  <= p_yel_d;
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: expiry edges are queued on each start and
// matched against every observed expired pulse.
module tb_interval_timer;

  localparam int unsigned TickDiv = 4;

  logic       clk = 1'b0;
  logic       reset_sync = 1'b1;
  logic       start_t = 1'b0;
  logic [1:0] interval = 2'b00;
  logic       prog_sync = 1'b0;
  logic [1:0] time_sel = 2'b00;
  logic [3:0] time_value = 4'd0;
  logic       expired;
  logic       tick_1hz;
  logic [3:0] remaining;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int exp_q[$];

  interval_timer #(
    .TICK_DIV(TickDiv),
    .DEF_BASE(6),
    .DEF_EXT (3),
    .DEF_YEL (2)
  ) dut (
    .clk       (clk),
    .reset_sync(reset_sync),
    .start_t   (start_t),
    .interval  (interval),
    .prog_sync (prog_sync),
    .time_sel  (time_sel),
    .time_value(time_value),
    .expired   (expired),
    .tick_1hz  (tick_1hz),
    .remaining (remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then scoreboard the expired output.
  task automatic step();
    int front;
    @(posedge clk);
    #1;
    if (expired === 1'b1) begin
      front = (exp_q.size() > 0) ? exp_q[0] : -1;
      chk("expired_edge", edge_cnt, front);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (expired !== 1'b0) begin
      chk("expired_known", 32'(expired), 0);
    end else if (exp_q.size() > 0 && exp_q[0] <= edge_cnt) begin
      chk("expired_missing", 0, 1);
      void'(exp_q.pop_front());
    end
  endtask

  // Start is sampled at the next edge; any pending expiry is abandoned.
  task automatic start(input logic [1:0] iv, input int load);
    start_t  = 1'b1;
    interval = iv;
    step();
    start_t = 1'b0;
    exp_q.delete();
    exp_q.push_back(edge_cnt + load * TickDiv);
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] val);
    prog_sync  = 1'b1;
    time_sel   = sel;
    time_value = val;
    step();
    prog_sync = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("wait_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    repeat (3) step();
  endtask

  initial begin
    // Reset defaults
    repeat (3) step();
    reset_sync = 1'b0;
    chk("rst_expired", 32'(expired), 0);
    chk("rst_remaining", 32'(remaining), 0);
    chk("rst_tick", 32'(tick_1hz), 0);
    repeat (5) step();

    start(2'b00, 6);
    chk("base_rem_load", 32'(remaining), 6);
    chk("base_tick_lo", 32'(tick_1hz), 0);
    for (int j = 1; j <= 6; j++) begin
      repeat (TickDiv - 1) step();
      chk("base_tick_hi", 32'(tick_1hz), 1);
      step();
      chk("base_rem_step", 32'(remaining), 32'(6 - j));
    end
    wait_idle(10);
    chk("idle_rem", 32'(remaining), 0);

    // Programming extended, then start one cycle later
    prog(2'b01, 4'd9);
    start(2'b01, 9);
    chk("ext_rem_load", 32'(remaining), 9);
    wait_idle(60);

    // Zero yellow loads as one second; reserved interval selects base
    prog(2'b10, 4'd0);
    start(2'b10, 1);
    chk("yel0_rem", 32'(remaining), 1);
    wait_idle(20);
    start(2'b11, 6);
    chk("rsv_rem", 32'(remaining), 6);
    wait_idle(40);

    // Reserved parameter write is ignored
    prog(2'b11, 4'd1);
    start(2'b00, 6);
    wait_idle(40);

    // Restart at k+10 abandons the first interval
    start(2'b00, 6);
    repeat (9) step();
    start(2'b00, 6);
    wait_idle(40);

    // Start coincident with DONE
    start(2'b00, 6);
    repeat (6 * TickDiv) step();
    start(2'b00, 6);
    chk("done_restart_exp", 32'(expired), 0);
    chk("done_restart_rem", 32'(remaining), 6);
    wait_idle(40);

    // Write and start in the same cycle: load uses the old base
    prog_sync  = 1'b1;
    time_sel   = 2'b00;
    time_value = 4'd2;
    start(2'b00, 6);
    prog_sync = 1'b0;
    chk("coll_rem_old", 32'(remaining), 6);
    wait_idle(40);
    start(2'b00, 2);
    chk("coll_rem_new", 32'(remaining), 2);
    wait_idle(20);

    // Reset mid-operation
    prog(2'b00, 4'd15);
    prog(2'b01, 4'd7);
    prog(2'b10, 4'd5);
    start(2'b00, 15);
    repeat (9) step();
    reset_sync = 1'b1;
    exp_q.delete();
    step();
    reset_sync = 1'b0;
    chk("midrst_rem", 32'(remaining), 0);
    chk("midrst_exp", 32'(expired), 0);
    repeat (70) step();
    start(2'b00, 6);
    chk("midrst_base", 32'(remaining), 6);
    wait_idle(40);
    start(2'b01, 3);
    chk("midrst_ext", 32'(remaining), 3);
    wait_idle(30);
    start(2'b10, 2);
    chk("midrst_yel", 32'(remaining), 2);
    wait_idle(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
